// File: rtl/indirect_accum_pkg.sv
// indirect_accum_pkg
// Shared constants, FSM state type and upper-triangle index helper for the
// indirect-term accumulator (normal matrix H and vector b of the pose solve).
// Optional feature macro used by the files importing this package:
//   INDIRECT_ACCUM_SAT_EN - saturating accumulation plus sticky overflow flag.
package indirect_accum_pkg;

    localparam int ID_COE_BW  = 16;   // Jacobian coefficient width (signed)
    localparam int H_SIZE_BW  = 11;   // horizontal image size width
    localparam int V_SIZE_BW  = 10;   // vertical image size width
    localparam int ACC_MAT_BW = 64;   // default accumulator width
    localparam int H_TRI_NUM  = 21;   // upper-triangle entries of 6x6 H
    localparam int B_NUM      = 6;    // entries of b
    localparam int PROD_BW    = 2 * ID_COE_BW + 1;  // full-width product sum

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN0,
        ST_DRAIN1
    } acc_state_t;

    // Row-major position of H(i,j), i<=j, inside the packed upper triangle.
    function automatic int tri_idx(input int i, input int j);
        return 6 * i - (i * (i - 1)) / 2 + (j - i);
    endfunction

endpackage

// File: rtl/indirect_accum_if.sv
// indirect_accum_if
// Sample/result bundle between the indirect-term stage and the accumulator.
//   start, valid, frame_end : frame framing and sample qualifier
//   ax, ay                  : packed Ax_0..5 / Ay_0..5 (index 0 at LSBs), signed
//   diffs_x, diffs_y        : signed pixel residuals
//   busy, done              : accumulator status, done is a one-cycle pulse
//   h, b, count             : latched results (H upper triangle row-major, b, samples)
//   ovf                     : sticky saturation flag (only with INDIRECT_ACCUM_SAT_EN)
// modport master drives samples, modport slave is the accumulator side.
interface indirect_accum_if
    import indirect_accum_pkg::*;
#(
    parameter int MAT_BW = ACC_MAT_BW,
    parameter int CNT_BW = H_SIZE_BW + V_SIZE_BW
);

    logic                          start;
    logic                          valid;
    logic                          frame_end;
    logic [6*ID_COE_BW-1:0]        ax;
    logic [6*ID_COE_BW-1:0]        ay;
    logic signed [H_SIZE_BW:0]     diffs_x;
    logic signed [V_SIZE_BW:0]     diffs_y;
    logic                          busy;
    logic                          done;
    logic [H_TRI_NUM*MAT_BW-1:0]   h;
    logic [B_NUM*MAT_BW-1:0]       b;
    logic [CNT_BW-1:0]             count;
`ifdef INDIRECT_ACCUM_SAT_EN
    logic                          ovf;

    modport master (
        output start, valid, frame_end, ax, ay, diffs_x, diffs_y,
        input  busy, done, h, b, count, ovf
    );
    modport slave (
        input  start, valid, frame_end, ax, ay, diffs_x, diffs_y,
        output busy, done, h, b, count, ovf
    );
`else
    modport master (
        output start, valid, frame_end, ax, ay, diffs_x, diffs_y,
        input  busy, done, h, b, count
    );
    modport slave (
        input  start, valid, frame_end, ax, ay, diffs_x, diffs_y,
        output busy, done, h, b, count
    );
`endif

endinterface

// File: rtl/indirect_accum_mac_entry.sv
// indirect_accum_mac_entry (mac_entry unit)
// One H or b entry: stage 1 registers (a0*b0 + a1*b1) >>> PROD_SHIFT extended
// to MAT_BW, stage 2 adds it into the accumulator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clears the accumulator (frame start); wins over a pending add
//   en       : operands are a sample to be accumulated
//   a0,b0,a1,b1 : signed operand pairs
//   acc      : running accumulator
//   sat      : this cycle's add saturated (only with INDIRECT_ACCUM_SAT_EN)
module indirect_accum_mac_entry
    import indirect_accum_pkg::*;
#(
    parameter int MAT_BW     = ACC_MAT_BW,
    parameter int PROD_SHIFT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [ID_COE_BW-1:0] a0,
    input  logic signed [ID_COE_BW-1:0] b0,
    input  logic signed [ID_COE_BW-1:0] a1,
    input  logic signed [ID_COE_BW-1:0] b1,
    output logic signed [MAT_BW-1:0]    acc
`ifdef INDIRECT_ACCUM_SAT_EN
    ,
    output logic                        sat
`endif
);

    logic signed [MAT_BW-1:0] prod_p1;
    logic                     vld_p1;
    logic signed [MAT_BW-1:0] sum_p1;

    // Full-width product sum, arithmetic shift, then sign-extend (or wrap
    // when MAT_BW is narrower than the product) to the accumulator width.
    function automatic logic signed [MAT_BW-1:0] scale_prod(
        input logic signed [ID_COE_BW-1:0] x0,
        input logic signed [ID_COE_BW-1:0] y0,
        input logic signed [ID_COE_BW-1:0] x1,
        input logic signed [ID_COE_BW-1:0] y1
    );
        logic signed [PROD_BW-1:0]        p;
        logic        [PROD_BW+MAT_BW-1:0] e;
        p = PROD_BW'(x0) * PROD_BW'(y0) + PROD_BW'(x1) * PROD_BW'(y1);
        p = p >>> PROD_SHIFT;
        e = {{MAT_BW{p[PROD_BW-1]}}, p};
        return $signed(e[MAT_BW-1:0]);
    endfunction

    // ---- stage 1: product sum ----
    always_ff @(posedge clk) begin
        prod_p1 <= scale_prod(a0, b0, a1, b1);
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= en;
        end
    end

`ifdef INDIRECT_ACCUM_SAT_EN
    function automatic logic signed [MAT_BW-1:0] sat_add(
        input  logic signed [MAT_BW-1:0] x,
        input  logic signed [MAT_BW-1:0] y,
        output logic                     hit
    );
        logic signed [MAT_BW:0] s;
        s   = {x[MAT_BW-1], x} + {y[MAT_BW-1], y};
        hit = (s[MAT_BW] != s[MAT_BW-1]);
        if (!hit) begin
            return $signed(s[MAT_BW-1:0]);
        end else if (s[MAT_BW]) begin
            return {1'b1, {(MAT_BW-1){1'b0}}};
        end else begin
            return {1'b0, {(MAT_BW-1){1'b1}}};
        end
    endfunction

    logic hit;

    always_comb begin
        hit    = 1'b0;
        sum_p1 = sat_add(acc, prod_p1, hit);
        // A pending add discarded by clr cannot flag overflow.
        sat    = vld_p1 && !clr && hit;
    end
`else
    assign sum_p1 = acc + prod_p1;
`endif

    // ---- stage 2: accumulate ----
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (vld_p1) begin
            acc <= sum_p1;
        end
    end

endmodule

// File: rtl/indirect_accum.sv
// indirect_accum
// Accumulates over one frame the upper triangle of H = sum(Ax*Ax' + Ay*Ay')
// and b = sum(Ax*dx + Ay*dy), one result set per frame flagged by done.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : samples in (start/valid/frame_end/ax/ay/diffs), results out
//                  (busy/done/h/b/count, plus ovf with INDIRECT_ACCUM_SAT_EN)
// Optional macro INDIRECT_ACCUM_SAT_EN: saturating adds and sticky ovf flag.
// frame_end sampled at edge t gives done (and loaded results) after edge t+2.
module indirect_accum
    import indirect_accum_pkg::*;
#(
    parameter int MAT_BW     = ACC_MAT_BW,
    parameter int PROD_SHIFT = 0,
    parameter int CNT_BW     = H_SIZE_BW + V_SIZE_BW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    indirect_accum_if.slave bus
);

    acc_state_t                 state;
    logic                       busy_q;
    logic                       done_q;
    logic [CNT_BW-1:0]          cnt;
    logic [CNT_BW-1:0]          cnt_q;
    logic signed [ID_COE_BW-1:0] ax [6];
    logic signed [ID_COE_BW-1:0] ay [6];
    logic signed [ID_COE_BW-1:0] dx;
    logic signed [ID_COE_BW-1:0] dy;
    logic                       acc_en;
    logic signed [MAT_BW-1:0]   acc_h [H_TRI_NUM];
    logic signed [MAT_BW-1:0]   acc_b [B_NUM];
    logic signed [MAT_BW-1:0]   h_q   [H_TRI_NUM];
    logic signed [MAT_BW-1:0]   b_q   [B_NUM];
`ifdef INDIRECT_ACCUM_SAT_EN
    logic [H_TRI_NUM+B_NUM-1:0] sat_hit;
    logic                       ovf_acc;
    logic                       ovf_q;
`endif

    function automatic logic [CNT_BW-1:0] cnt_inc(input logic [CNT_BW-1:0] c);
        return (&c) ? c : c + CNT_BW'(1);
    endfunction

    for (genvar k = 0; k < 6; k++) begin : g_unpack
        assign ax[k] = bus.ax[k*ID_COE_BW +: ID_COE_BW];
        assign ay[k] = bus.ay[k*ID_COE_BW +: ID_COE_BW];
    end

    assign dx = {{(ID_COE_BW-H_SIZE_BW-1){bus.diffs_x[H_SIZE_BW]}}, bus.diffs_x};
    assign dy = {{(ID_COE_BW-V_SIZE_BW-1){bus.diffs_y[V_SIZE_BW]}}, bus.diffs_y};

    // A start cycle already counts as an accumulating cycle.
    assign acc_en = bus.valid && (bus.start || state == ST_ACC);

    for (genvar i = 0; i < 6; i++) begin : g_row
        for (genvar j = i; j < 6; j++) begin : g_col
            localparam int K = tri_idx(i, j);
            indirect_accum_mac_entry #(
                .MAT_BW     (MAT_BW),
                .PROD_SHIFT (PROD_SHIFT)
            ) u_h (
                .clk (i_clk),
                .rst (i_rst),
                .clr (bus.start),
                .en  (acc_en),
                .a0  (ax[i]),
                .b0  (ax[j]),
                .a1  (ay[i]),
                .b1  (ay[j]),
                .acc (acc_h[K])
`ifdef INDIRECT_ACCUM_SAT_EN
                ,
                .sat (sat_hit[K])
`endif
            );
        end
    end

    for (genvar k = 0; k < B_NUM; k++) begin : g_b
        indirect_accum_mac_entry #(
            .MAT_BW     (MAT_BW),
            .PROD_SHIFT (PROD_SHIFT)
        ) u_b (
            .clk (i_clk),
            .rst (i_rst),
            .clr (bus.start),
            .en  (acc_en),
            .a0  (ax[k]),
            .b0  (dx),
            .a1  (ay[k]),
            .b1  (dy),
            .acc (acc_b[k])
`ifdef INDIRECT_ACCUM_SAT_EN
            ,
            .sat (sat_hit[H_TRI_NUM+k])
`endif
        );
    end

    // Frame control; start overrides every state, including frame_end in
    // the same cycle. The two drain states let the mac pipeline settle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            cnt_q  <= '0;
            for (int k = 0; k < H_TRI_NUM; k++) h_q[k] <= '0;
            for (int k = 0; k < B_NUM; k++)     b_q[k] <= '0;
`ifdef INDIRECT_ACCUM_SAT_EN
            ovf_acc <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef INDIRECT_ACCUM_SAT_EN
            if (bus.start) begin
                ovf_acc <= 1'b0;
            end else if (|sat_hit) begin
                ovf_acc <= 1'b1;
            end
`endif
            if (bus.start) begin
                state  <= ST_ACC;
                busy_q <= 1'b1;
                cnt    <= bus.valid ? CNT_BW'(1) : '0;
            end else begin
                case (state)
                    ST_ACC: begin
                        if (bus.valid) cnt <= cnt_inc(cnt);
                        if (bus.frame_end) state <= ST_DRAIN0;
                    end
                    ST_DRAIN0: begin
                        state <= ST_DRAIN1;
                    end
                    ST_DRAIN1: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt_q  <= cnt;
                        for (int k = 0; k < H_TRI_NUM; k++) h_q[k] <= acc_h[k];
                        for (int k = 0; k < B_NUM; k++)     b_q[k] <= acc_b[k];
`ifdef INDIRECT_ACCUM_SAT_EN
                        ovf_q <= ovf_acc;
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < H_TRI_NUM; k++) begin : g_hout
        assign bus.h[k*MAT_BW +: MAT_BW] = h_q[k];
    end
    for (genvar k = 0; k < B_NUM; k++) begin : g_bout
        assign bus.b[k*MAT_BW +: MAT_BW] = b_q[k];
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = cnt_q;
`ifdef INDIRECT_ACCUM_SAT_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_indirect_accum.sv
// Bench for indirect_accum: three instances (default, PROD_SHIFT=4, MAT_BW=16)
// share one stimulus stream; expectations come from hand-computed vectors and
// a sample-queue reference model evaluated per frame.
module tb_indirect_accum;
    import indirect_accum_pkg::*;

    localparam int CNT_BW = H_SIZE_BW + V_SIZE_BW;
    localparam int NE     = 27;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic st, vl, fe;
    logic signed [15:0] sax [6];
    logic signed [15:0] say [6];
    logic signed [11:0] sdx;
    logic signed [10:0] sdy;
    logic [95:0] pax, pay;

    always_comb begin
        pax = '0;
        pay = '0;
        for (int i = 0; i < 6; i++) begin
            pax[i*16 +: 16] = sax[i];
            pay[i*16 +: 16] = say[i];
        end
    end

    indirect_accum_if #(.MAT_BW(64), .CNT_BW(CNT_BW)) if0 ();
    indirect_accum_if #(.MAT_BW(64), .CNT_BW(CNT_BW)) if1 ();
    indirect_accum_if #(.MAT_BW(16), .CNT_BW(CNT_BW)) if2 ();

    assign if0.start = st;  assign if1.start = st;  assign if2.start = st;
    assign if0.valid = vl;  assign if1.valid = vl;  assign if2.valid = vl;
    assign if0.frame_end = fe; assign if1.frame_end = fe; assign if2.frame_end = fe;
    assign if0.ax = pax; assign if1.ax = pax; assign if2.ax = pax;
    assign if0.ay = pay; assign if1.ay = pay; assign if2.ay = pay;
    assign if0.diffs_x = sdx; assign if1.diffs_x = sdx; assign if2.diffs_x = sdx;
    assign if0.diffs_y = sdy; assign if1.diffs_y = sdy; assign if2.diffs_y = sdy;

    indirect_accum #(.MAT_BW(64), .PROD_SHIFT(0), .CNT_BW(CNT_BW))
        dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    indirect_accum #(.MAT_BW(64), .PROD_SHIFT(4), .CNT_BW(CNT_BW))
        dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    indirect_accum #(.MAT_BW(16), .PROD_SHIFT(0), .CNT_BW(CNT_BW))
        dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    // ---------------- reference model ----------------
    typedef struct {
        longint ax [6];
        longint ay [6];
        longint dx;
        longint dy;
    } smp_t;

    smp_t q [$];
    bit   in_frame;
    int   ti [21];
    int   tj [21];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic longint wrap16(input longint x);
        shortint s;
        s = shortint'(x);
        return longint'(s);
    endfunction

    function automatic longint term(input smp_t s, input int k);
        if (k < 21) return s.ax[ti[k]] * s.ax[tj[k]] + s.ay[ti[k]] * s.ay[tj[k]];
        return s.ax[k-21] * s.dx + s.ay[k-21] * s.dy;
    endfunction

    // Frame result for entry k from the accepted samples of the frame.
    function automatic longint model_val(input int k, input int shift, input int w,
                                         output bit ovf);
        longint acc = 0;
        longint t, s;
        ovf = 1'b0;
        foreach (q[n]) begin
            t = term(q[n], k) >>> shift;
            if (w == 16) begin
                t = wrap16(t);
                s = acc + t;
`ifdef INDIRECT_ACCUM_SAT_EN
                if (s > 32767) begin s = 32767; ovf = 1'b1; end
                else if (s < -32768) begin s = -32768; ovf = 1'b1; end
`else
                s = wrap16(s);
`endif
                acc = s;
            end else begin
                acc = acc + t;
            end
        end
        return acc;
    endfunction

    function automatic longint dut_val(input int d, input int k);
        longint r;
        r = 0;
        if (d == 0) begin
            if (k < 21) r = $signed(if0.h[k*64 +: 64]); else r = $signed(if0.b[(k-21)*64 +: 64]);
        end else if (d == 1) begin
            if (k < 21) r = $signed(if1.h[k*64 +: 64]); else r = $signed(if1.b[(k-21)*64 +: 64]);
        end else begin
            if (k < 21) r = $signed(if2.h[k*16 +: 16]); else r = $signed(if2.b[(k-21)*16 +: 16]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_sample();
        for (int i = 0; i < 6; i++) begin sax[i] = 0; say[i] = 0; end
        sdx = 0;
        sdy = 0;
    endtask

    task automatic rand_sample();
        for (int i = 0; i < 6; i++) begin
            sax[i] = 16'($urandom);
            say[i] = 16'($urandom);
        end
        sdx = 12'($urandom);
        sdy = 11'($urandom);
    endtask

    task automatic drive_cycle(input bit s, input bit v, input bit f);
        smp_t cur;
        st = s; vl = v; fe = f;
        for (int i = 0; i < 6; i++) begin cur.ax[i] = sax[i]; cur.ay[i] = say[i]; end
        cur.dx = sdx;
        cur.dy = sdy;
        if (s) begin
            q.delete();
            in_frame = 1'b1;
            if (v) q.push_back(cur);
        end else if (in_frame) begin
            if (v) q.push_back(cur);
            if (f) in_frame = 1'b0;
        end
        @(posedge clk);
        #1;
        st = 1'b0; vl = 1'b0; fe = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        bit     o, ovf_any;
        longint e;
        ovf_any = 1'b0;
        for (int k = 0; k < NE; k++) begin
            e = model_val(k, 0, 64, o);
            chk($sformatf("%s d0 e%0d", tag, k), dut_val(0, k), e);
            e = model_val(k, 4, 64, o);
            chk($sformatf("%s d1 e%0d", tag, k), dut_val(1, k), e);
            e = model_val(k, 0, 16, o);
            ovf_any |= o;
            chk($sformatf("%s d2 e%0d", tag, k), dut_val(2, k), e);
        end
        chk({tag, " count0"}, longint'(if0.count), longint'(q.size()));
        chk({tag, " count2"}, longint'(if2.count), longint'(q.size()));
`ifdef INDIRECT_ACCUM_SAT_EN
        chk({tag, " ovf0"}, longint'(if0.ovf), 0);
        chk({tag, " ovf2"}, longint'(if2.ovf), longint'(ovf_any));
`endif
    endtask

    // frame_end cycle, then bounded wait for done with junk on the inputs.
    task automatic finish_frame(input string tag, input bit v_last);
        int got;
        drive_cycle(1'b0, v_last, 1'b1);
        got = 0;
        for (int n = 1; n <= 8 && got == 0; n++) begin
            rand_sample();
            drive_cycle(1'b0, 1'($urandom % 2), 1'($urandom % 2));
            if (if0.done) begin
                got = n;
                chk({tag, " done1"}, longint'(if1.done), 1);
                chk({tag, " done2"}, longint'(if2.done), 1);
                chk({tag, " busy"}, longint'(if0.busy), 0);
            end
        end
        chk({tag, " done_latency"}, got, 2);
        check_frame(tag);
        drive_cycle(1'b0, 1'b0, 1'b0);
        chk({tag, " done_pulse"}, longint'(if0.done), 0);
    endtask

    typedef struct {
        int     ax [6];
        int     ay [6];
        int     dx;
        int     dy;
        longint h00, h15, h55, b0, b5;
    } vec_t;

    vec_t tbl [3];

    initial begin
        int n;
        int seen;
        n = 0;
        for (int i = 0; i < 6; i++)
            for (int j = i; j < 6; j++) begin ti[n] = i; tj[n] = j; n++; end

        st = 0; vl = 0; fe = 0; in_frame = 0;
        clear_sample();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", longint'(if0.busy), 0);
        chk("reset done", longint'(if0.done), 0);
        chk("reset count", longint'(if0.count), 0);
        chk("reset h00", dut_val(0, 0), 0);
        chk("reset b5", dut_val(2, 26), 0);

        // single-sample frames with hand-derived results
        tbl[0] = '{'{1,2,3,4,5,6}, '{1,2,3,4,5,6}, 2, -1, 2, 24, 72, 1, 6};
        tbl[1] = '{'{-3,1,0,0,0,2}, '{4,0,0,0,0,-5}, 10, -2, 25, 2, 29, -38, 30};
        tbl[2] = '{'{-32768,0,0,0,0,32767}, '{-32768,0,0,0,0,32767}, 2047, -1024,
                   64'sd2147483648, 0, 64'sd2147352578, -64'sd33521664, 64'sd33520641};
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 6; i++) begin
                sax[i] = 16'(tbl[v].ax[i]);
                say[i] = 16'(tbl[v].ay[i]);
            end
            sdx = 12'(tbl[v].dx);
            sdy = 11'(tbl[v].dy);
            drive_cycle(1'b1, 1'b1, 1'b0);
            chk($sformatf("vec%0d busy", v), longint'(if0.busy), 1);
            finish_frame($sformatf("vec%0d", v), 1'b0);
            chk($sformatf("vec%0d h00", v), dut_val(0, 0), tbl[v].h00);
            chk($sformatf("vec%0d h15", v), dut_val(0, 10), tbl[v].h15);
            chk($sformatf("vec%0d h55", v), dut_val(0, 20), tbl[v].h55);
            chk($sformatf("vec%0d b0", v), dut_val(0, 21), tbl[v].b0);
            chk($sformatf("vec%0d b5", v), dut_val(0, 26), tbl[v].b5);
            chk($sformatf("vec%0d count", v), longint'(if0.count), 1);
        end

        // 100 valid samples with 20 idle cycles interleaved
        clear_sample();
        sax[0] = 1;
        sdx = 3;
        for (int c = 0; c < 120; c++) drive_cycle(c == 0, (c % 6) != 5, 1'b0);
        finish_frame("hundred", 1'b0);
        chk("hundred h00", dut_val(0, 0), 100);
        chk("hundred b0", dut_val(0, 21), 300);
        chk("hundred count", longint'(if0.count), 100);

        // restart mid-frame: only the last five samples survive
        for (int c = 0; c < 10; c++) begin rand_sample(); drive_cycle(c == 0, 1'b1, 1'b0); end
        for (int c = 0; c < 5; c++) begin rand_sample(); drive_cycle(c == 0, 1'b1, 1'b0); end
        finish_frame("restart", 1'b0);
        chk("restart count", longint'(if0.count), 5);

        // start and frame_end together: frame keeps running, no done
        rand_sample();
        drive_cycle(1'b1, 1'b1, 1'b1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            if (if0.done) seen++;
        end
        chk("start_fe no_done", seen, 0);
        chk("start_fe busy", longint'(if0.busy), 1);
        finish_frame("start_fe", 1'b0);
        chk("start_fe count", longint'(if0.count), 1);

        // reset during DRAIN0 aborts the frame and clears the results
        for (int c = 0; c < 5; c++) begin rand_sample(); drive_cycle(c == 0, 1'b1, 1'b0); end
        drive_cycle(1'b0, 1'b1, 1'b1);
        chk("drain0 busy", longint'(if0.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_frame = 1'b0;
        q.delete();
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            if (if0.done) seen++;
        end
        chk("rst_drain no_done", seen, 0);
        chk("rst_drain h00", dut_val(0, 0), 0);
        chk("rst_drain b0", dut_val(0, 21), 0);
        chk("rst_drain count", longint'(if0.count), 0);
        chk("rst_drain busy", longint'(if0.busy), 0);

        // valid and frame_end while idle do nothing
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            rand_sample();
            drive_cycle(1'b0, 1'b1, 1'b1);
            if (if0.done || if0.busy) seen++;
        end
        chk("idle ignore", seen, 0);
        chk("idle h00", dut_val(0, 0), 0);
        chk("idle count", longint'(if0.count), 0);

        // product shift
        clear_sample();
        sax[0] = 16; say[0] = 16; sdx = 16; sdy = 16;
        drive_cycle(1'b1, 1'b1, 1'b0);
        finish_frame("shift", 1'b0);
        chk("shift h00", dut_val(1, 0), 32);
        chk("shift b0", dut_val(1, 21), 32);
        chk("noshift h00", dut_val(0, 0), 512);

        // narrow accumulator overflow
        clear_sample();
        sax[0] = 127; say[0] = 127;
        for (int c = 0; c < 10; c++) drive_cycle(c == 0, 1'b1, 1'b0);
        finish_frame("narrow", 1'b0);
`ifdef INDIRECT_ACCUM_SAT_EN
        chk("narrow h00 sat", dut_val(2, 0), 32767);
        chk("narrow ovf", longint'(if2.ovf), 1);
`else
        chk("narrow h00 wrap", dut_val(2, 0), -5100);
`endif
        chk("narrow h00 wide", dut_val(0, 0), 322580);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            int len;
            len = 1 + int'($urandom % 25);
            for (int c = 0; c < len; c++) begin
                rand_sample();
                drive_cycle(c == 0, 1'($urandom % 4 != 0), 1'b0);
            end
            rand_sample();
            finish_frame($sformatf("rnd%0d", f), 1'($urandom % 2));
            repeat (int'($urandom % 3)) drive_cycle(1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/indirect_accum.md
Name: indirect_accum

Overview:
- Downstream consumer of the indirect-term calculation stage. Takes its per-pixel Jacobian rows (Ax_0..5, Ay_0..5) and pixel residuals (diffs_x/y).
- Accumulates over one frame the 6x6 normal matrix H = sum(Ax·Axᵀ + Ay·Ayᵀ), upper triangle only (21 terms), and the 6-vector b = sum(Ax·dx + Ay·dy).
- Results feed the pose solver; one result set per frame, flagged by a done pulse.

Parameters:
- MAT_BW, 64, accumulator width per H/b entry (signed)
- PROD_SHIFT, 0, arithmetic right shift applied to each product sum before accumulation
- CNT_BW, H_SIZE_BW+V_SIZE_BW, width of valid-sample counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  frame start pulse; aligned with the first sample of the frame
- i_valid  in  1  sample qualifier
- i_frame_end  in  1  pulse, asserted with or after the last sample
- i_Ax  in  6*ID_COE_BW  packed Ax_0..5 (Ax_0 at LSBs), signed
- i_Ay  in  6*ID_COE_BW  packed Ay_0..5, signed
- i_diffs_x  in  H_SIZE_BW+1  signed residual x
- i_diffs_y  in  V_SIZE_BW+1  signed residual y
- o_busy  out  1  high in ACC/DRAIN
- o_done  out  1  one-cycle pulse; results valid
- o_H  out  21*MAT_BW  upper triangle, row-major; entry k(i,j)=6i−i(i−1)/2+(j−i), i≤j
- o_b  out  6*MAT_BW  b_0..5
- o_count  out  CNT_BW  number of accumulated samples

Behaviour:
- Reset (i_rst=1 at posedge): state IDLE; all accumulators, o_H, o_b, o_count = 0; o_done = 0; o_busy = 0. Any operation in progress is aborted.
- FSM states: IDLE, ACC, DRAIN0, DRAIN1.
  - i_start in any state → ACC. Accumulators and counter cleared. A sample with i_valid in that same cycle is the first accumulated term.
  - ACC & i_frame_end → DRAIN0 (sample in that cycle is included if valid) → DRAIN1 → IDLE. On the DRAIN1→IDLE edge, o_H/o_b/o_count are loaded from the accumulators and o_done=1 for that cycle.
  - i_start and i_frame_end in the same cycle: start wins; frame_end is ignored.
  - i_valid in IDLE/DRAIN0/DRAIN1 is ignored (no accumulation). i_frame_end outside ACC is ignored.
- Pipeline: stage 1 registers the 27 product sums (with valid). Stage 2 adds them into the accumulators. Latency: frame_end at cycle t → o_done at t+2, including all valid samples up to t.
- Arithmetic:
  - Diffs are sign-extended to ID_COE_BW.
  - Each product sum (Ax_i·Ax_j+Ay_i·Ay_j or Ax_i·dx+Ay_i·dy) is computed at full width 2·ID_COE_BW+1, arithmetically shifted right by PROD_SHIFT, then sign-extended to MAT_BW.
  - Default accumulation wraps (two's complement).
- o_count saturates at all-ones.
- o_H/o_b/o_count hold their value until the next o_done or reset.

Optional Feature:
- Macro INDIRECT_ACCUM_SAT_EN.
- Defined: each accumulator add saturates to the MAX/MIN signed values of MAT_BW. A sticky o_ovf output (1 bit, cleared by i_start/i_rst) is set when any saturation occurs. o_ovf is latched with the results at o_done.
- Undefined: adds wrap and the o_ovf port does not exist.

Decomposition:
- Add to RgbdVoConfigPk:
  - constants ACC_MAT_BW, H_TRI_NUM=21, B_NUM=6
  - function tri_idx(i,j)
  - typedef enum for FSM states
- One sub-module: mac_entry. It takes two operand pairs, forms the registered product sum and shift (stage 1), then does the accumulate with clear, enable and optional saturation (stage 2). The block instantiates it 27 times via generate.

Test Plan:
- Single sample: start+valid with Ax=Ay=(1,2,3,4,5,6), dx=2, dy=−1, frame_end same-or-next cycle → o_done at frame_end+2; H(0,0)=2, H(1,5)=24, H(5,5)=72; b_i=Ax_i; count=1.
- 100 valid samples of Ax=(1,0,0,0,0,0), Ay=0, dx=3, with 20 invalid cycles interleaved → H(0,0)=100, b_0=300, all other entries 0, count=100.
- Start re-issued mid-frame after 10 samples, then 5 samples and frame_end → count=5, results from the last 5 only. Start+frame_end in the same cycle → no o_done.
- Reset asserted during DRAIN0 → no o_done; outputs 0. Valid/frame_end while IDLE → no effect.
- PROD_SHIFT=4, Ax_0=Ay_0=16, dx=16, one sample → H(0,0)=32, b_0=32.
- With INDIRECT_ACCUM_SAT_EN, MAT_BW=16, Ax_0=Ay_0=127, 10 samples → H(0,0)=32767 and o_ovf=1. Without the macro → wrapped value 322580 mod 2^16 as signed.
